// File: rtl/jk_modn_updown_counter.sv
// Mod-N up/down counter built on JK state bits; exports per-bit J/K excitation
// so an external gate-level JK flip-flop bank can track the same sequence.
module jk_modn_updown_counter #(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned MODULUS = 10
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             En,
  input  logic             Up,
  input  logic             Load,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] J,
  output logic [WIDTH-1:0] K,
  output logic             Tc,
  output logic             Carry,
  output logic             Err
);

  // One extra bit so MODULUS == 2**WIDTH is representable for the load check
  localparam int unsigned CMP_W = WIDTH + 1;
  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
  localparam logic [CMP_W-1:0] MOD_EXT = CMP_W'(MODULUS);

  logic [WIDTH-1:0] q_q, q_d;
  logic             carry_q, carry_d;
  logic             err_q, err_d;

  logic [WIDTH-1:0] target;
  logic             d_legal;
  logic             at_max;
  logic             at_zero;

  assign d_legal = ({1'b0, D} < MOD_EXT);
  assign at_max  = (q_q == MAX_VAL);
  assign at_zero = (q_q == '0);

  // Requested next state, priority Rst > Load > En > hold
  always_comb begin
    target = q_q;
    if (Rst) begin
      target = '0;
    end else if (Load) begin
      target = d_legal ? D : '0;
    end else if (En) begin
      if (Up) begin
        target = at_max ? '0 : q_q + WIDTH'(1);
      end else begin
        target = at_zero ? MAX_VAL : q_q - WIDTH'(1);
      end
    end
  end

  // Excitation with don't-cares resolved to 0, then JK characteristic equation
  always_comb begin
    J       = ~q_q & target;
    K       = q_q & ~target;
    q_d     = (J & ~q_q) | (~K & q_q);
    Tc      = En & ~Load & ~Rst & ((Up & at_max) | (~Up & at_zero));
    carry_d = Tc;
    err_d   = err_q | (Load & ~d_legal);
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      q_q     <= '0;
      carry_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      q_q     <= q_d;
      carry_q <= carry_d;
      err_q   <= err_d;
    end
  end

  assign Q     = q_q;
  assign Carry = carry_q;
  assign Err   = err_q;

endmodule

// File: tb/tb_jk_modn_updown_counter.sv
// Self-checking bench for jk_modn_updown_counter: directed scenarios plus a
// randomized run against an arithmetic reference model.
module tb_jk_modn_updown_counter;

  localparam int unsigned W = 4;
  localparam int unsigned M = 10;

  logic         Clk = 1'b0;
  logic         Rst, En, Up, Load;
  logic [W-1:0] D;
  logic [W-1:0] Q, J, K;
  logic         Tc, Carry, Err;

  int n_tests = 0;
  int n_fail  = 0;

  jk_modn_updown_counter #(.WIDTH(W), .MODULUS(M)) dut (
    .Clk(Clk), .Rst(Rst), .En(En), .Up(Up), .Load(Load), .D(D),
    .Q(Q), .J(J), .K(K), .Tc(Tc), .Carry(Carry), .Err(Err)
  );

  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic drive(input logic rst, input logic load, input logic en,
                       input logic up, input logic [W-1:0] d);
    Rst = rst; Load = load; En = en; Up = up; D = d;
    #1;
  endtask

  // Reference model: next count from plain modular arithmetic
  function automatic int ref_next(input int q, input bit rst, input bit load,
                                  input bit en, input bit up, input int d);
    if (rst)       return 0;
    if (load)      return (d < M) ? d : 0;
    if (en && up)  return (q + 1) % M;
    if (en)        return (q + M - 1) % M;
    return q;
  endfunction

  function automatic bit ref_tc(input int q, input bit rst, input bit load,
                                input bit en, input bit up);
    if (rst || load || !en) return 1'b0;
    return up ? (q + 1 == M) : (q == 0);
  endfunction

  task automatic test_reset();
    drive(1, 0, 0, 0, '0); tick();
    drive(0, 1, 0, 0, 4'd12); tick();
    n_tests++;
    if (Err !== 1'b1) begin n_fail++; $display("FAIL reset_pre_err got %b want 1", Err); end
    drive(0, 1, 0, 0, 4'd7); tick();
    n_tests++;
    if (Q !== 4'd7) begin n_fail++; $display("FAIL reset_pre_q got %0d want 7", Q); end
    drive(1, 1, 1, 1, 4'd3);
    n_tests++;
    if (J !== 4'd0 || K !== 4'd7) begin
      n_fail++; $display("FAIL reset_jk got J=%b K=%b want J=0000 K=0111", J, K);
    end
    tick();
    n_tests++;
    if (Q !== 4'd0 || Carry !== 1'b0 || Err !== 1'b0) begin
      n_fail++; $display("FAIL reset_state got Q=%0d C=%b E=%b want 0 0 0", Q, Carry, Err);
    end
  endtask

  task automatic test_count_up();
    for (int i = 1; i <= 10; i++) begin
      drive(0, 0, 1, 1, '0);
      n_tests++;
      if (Tc !== (i == 10)) begin n_fail++; $display("FAIL up_tc step %0d got %b", i, Tc); end
      tick();
      n_tests++;
      if (Q !== W'(i % 10) || Carry !== (i == 10)) begin
        n_fail++; $display("FAIL up_step %0d got Q=%0d C=%b want Q=%0d C=%b", i, Q, Carry, i % 10, i == 10);
      end
    end
    drive(0, 0, 0, 1, '0); tick();
    n_tests++;
    if (Carry !== 1'b0) begin n_fail++; $display("FAIL up_carry_clear got %b want 0", Carry); end
  endtask

  task automatic test_count_down();
    drive(0, 0, 1, 0, '0);
    n_tests++;
    if (Tc !== 1'b1) begin n_fail++; $display("FAIL down_tc got %b want 1", Tc); end
    tick();
    n_tests++;
    if (Q !== 4'd9 || Carry !== 1'b1) begin
      n_fail++; $display("FAIL down_wrap got Q=%0d C=%b want 9 1", Q, Carry);
    end
    tick();
    n_tests++;
    if (Q !== 4'd8 || Carry !== 1'b0) begin
      n_fail++; $display("FAIL down_next got Q=%0d C=%b want 8 0", Q, Carry);
    end
    tick(); tick(); tick();
    n_tests++;
    if (Q !== 4'd5 || J !== 4'b0000 || K !== 4'b0001) begin
      n_fail++; $display("FAIL down_jk got Q=%0d J=%b K=%b want 5 0000 0001", Q, J, K);
    end
  endtask

  task automatic test_load();
    drive(0, 1, 0, 0, 4'd9); tick();
    drive(0, 1, 1, 1, 4'd6);
    n_tests++;
    if (Tc !== 1'b0) begin n_fail++; $display("FAIL load_tc got %b want 0", Tc); end
    tick();
    n_tests++;
    if (Q !== 4'd6 || Carry !== 1'b0) begin
      n_fail++; $display("FAIL load_legal got Q=%0d C=%b want 6 0", Q, Carry);
    end
    drive(0, 1, 0, 0, 4'd12); tick();
    n_tests++;
    if (Q !== 4'd0 || Err !== 1'b1) begin
      n_fail++; $display("FAIL load_illegal got Q=%0d E=%b want 0 1", Q, Err);
    end
    drive(0, 0, 1, 1, '0); tick(); tick(); tick();
    n_tests++;
    if (Q !== 4'd3 || Err !== 1'b1) begin
      n_fail++; $display("FAIL err_sticky got Q=%0d E=%b want 3 1", Q, Err);
    end
    drive(0, 1, 0, 0, 4'd2); tick();
    n_tests++;
    if (Q !== 4'd2 || Err !== 1'b1) begin
      n_fail++; $display("FAIL load_after_err got Q=%0d E=%b want 2 1", Q, Err);
    end
    drive(1, 0, 1, 1, '0); tick();
    n_tests++;
    if (Err !== 1'b0 || Q !== 4'd0) begin
      n_fail++; $display("FAIL err_clear got Q=%0d E=%b want 0 0", Q, Err);
    end
  endtask

  task automatic test_hold_and_toggle();
    logic [W-1:0] exp_seq [4];
    exp_seq[0] = 4'd4; exp_seq[1] = 4'd3; exp_seq[2] = 4'd4; exp_seq[3] = 4'd3;
    drive(0, 1, 0, 0, 4'd3); tick();
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 0, i[0], '0);
      n_tests++;
      if (J !== '0 || K !== '0 || Tc !== 1'b0) begin
        n_fail++; $display("FAIL hold_exc cycle %0d got J=%b K=%b Tc=%b want 0 0 0", i, J, K, Tc);
      end
      tick();
      n_tests++;
      if (Q !== 4'd3) begin n_fail++; $display("FAIL hold_q cycle %0d got %0d want 3", i, Q); end
    end
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 1, (i % 2 == 0), '0); tick();
      n_tests++;
      if (Q !== exp_seq[i]) begin
        n_fail++; $display("FAIL toggle_up step %0d got %0d want %0d", i, Q, exp_seq[i]);
      end
    end
  endtask

  task automatic test_random();
    int m_q = 0;
    bit m_carry = 1'b0;
    bit m_err = 1'b0;
    int t;
    bit etc;
    logic [W-1:0] qv, tv, ej, ek;
    bit r, l, e, u;
    int d;
    drive(1, 0, 0, 0, '0); tick();
    for (int c = 0; c < 10000; c++) begin
      r = ($urandom_range(63) == 0);
      l = ($urandom_range(7) == 0);
      e = ($urandom_range(3) != 0);
      u = $urandom_range(1);
      d = $urandom_range(15);
      drive(r, l, e, u, W'(d));
      t   = ref_next(m_q, r, l, e, u, d);
      etc = ref_tc(m_q, r, l, e, u);
      qv  = W'(m_q);
      tv  = W'(t);
      ej  = ~qv & tv;
      ek  = qv & ~tv;
      n_tests++;
      if (J !== ej || K !== ek || Tc !== etc) begin
        n_fail++;
        $display("FAIL rand_comb cyc %0d got J=%b K=%b Tc=%b want J=%b K=%b Tc=%b", c, J, K, Tc, ej, ek, etc);
      end
      n_tests++;
      if ((J & K) !== '0) begin n_fail++; $display("FAIL rand_jk_overlap cyc %0d J=%b K=%b", c, J, K); end
      tick();
      m_err   = r ? 1'b0 : (m_err | (l && d >= M));
      m_carry = etc;
      m_q     = t;
      n_tests++;
      if (Q !== W'(m_q) || Carry !== m_carry || Err !== m_err) begin
        n_fail++;
        $display("FAIL rand_state cyc %0d got Q=%0d C=%b E=%b want Q=%0d C=%b E=%b", c, Q, Carry, Err, m_q, m_carry, m_err);
      end
      n_tests++;
      if (!(int'(Q) < M)) begin n_fail++; $display("FAIL rand_range cyc %0d got Q=%0d", c, Q); end
    end
  endtask

  initial begin
    Rst = 1'b1; En = 1'b0; Up = 1'b0; Load = 1'b0; D = '0;
    test_reset();
    test_count_up();
    test_count_down();
    test_load();
    test_hold_and_toggle();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
